// File: rtl/eth_axis_tx_pkt_gen.sv
// AXI-Stream Ethernet TX frame generator: fixed-length frames with a
// (frame + byte offset) pattern, back-pressure, inter-packet gap, status.
module eth_axis_tx_pkt_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int TUSER_WIDTH = 1,
  parameter int LEN_WIDTH   = 14,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic [CNT_WIDTH-1:0]    cfg_pkt_cnt,
  input  logic [7:0]              cfg_ipg,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic [TUSER_WIDTH-1:0]  m_tuser,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    pkts_sent
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(64);
  localparam logic [LEN_WIDTH-1:0] STEP = LEN_WIDTH'(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_off;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_pkts;
  logic [7:0]            r_ipg;
  logic [7:0]            r_gap;
  logic [7:0]            r_frame;
  logic                  r_stop;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_data;
  logic [BYTES-1:0]      r_keep;

  logic [LEN_WIDTH-1:0]  w_len_c;
  logic                  w_acc;
  logic                  w_stop;
  logic                  w_end;
  logic [CNT_WIDTH-1:0]  w_pkts_inc;
  logic [7:0]            w_b_frame;
  logic [LEN_WIDTH-1:0]  w_b_off;
  logic [LEN_WIDTH-1:0]  w_b_len;
  logic [LEN_WIDTH-1:0]  w_rem;
  logic                  w_b_last;
  logic [BYTES-1:0]      w_b_keep;
  logic [DATA_WIDTH-1:0] w_b_data;

  // Upper clamp is implicit: the length field cannot exceed 2^LEN_WIDTH-1.
  assign w_len_c = (cfg_pkt_len < MIN_LEN) ? MIN_LEN : cfg_pkt_len;
  assign w_acc = r_valid & m_tready;
  assign w_stop = r_stop | cfg_stop;
  assign w_pkts_inc = (&r_pkts) ? r_pkts : r_pkts + CNT_WIDTH'(1);
  assign w_end = w_stop |
    ((r_cnt != '0) && (r_pkts + CNT_WIDTH'(1) == r_cnt));

  // Which beat gets loaded next: first of run, next of frame, or next frame.
  always_comb begin
    w_b_frame = 8'h00;
    w_b_off   = '0;
    w_b_len   = r_len;
    if (r_state == IDLE) begin
      w_b_len = w_len_c;
    end else if (r_last) begin
      w_b_frame = r_frame + 8'd1;
    end else begin
      w_b_frame = r_frame;
      w_b_off   = r_off + STEP;
    end
  end

  always_comb begin
    w_rem    = w_b_len - w_b_off;
    w_b_last = (w_rem <= STEP);
    w_b_keep = '0;
    w_b_data = '0;
    for (int k = 0; k < BYTES; k++) begin
      w_b_keep[k] = !w_b_last || (LEN_WIDTH'(k) < w_rem);
      if (w_b_keep[k])
        w_b_data[8*k +: 8] = w_b_frame + w_b_off[7:0] + 8'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_pkts  <= '0;
      r_ipg   <= '0;
      r_gap   <= '0;
      r_frame <= '0;
      r_stop  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_len   <= w_len_c;
            r_cnt   <= cfg_pkt_cnt;
            r_ipg   <= cfg_ipg;
            r_pkts  <= '0;
            r_frame <= '0;
            r_off   <= '0;
            r_stop  <= 1'b0;
            r_data  <= w_b_data;
            r_keep  <= w_b_keep;
            r_last  <= w_b_last;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (cfg_stop)
            r_stop <= 1'b1;
          if (w_acc) begin
            if (r_last)
              r_pkts <= w_pkts_inc;
            if (r_last && w_end) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_stop  <= 1'b0;
              r_data  <= '0;
              r_keep  <= '0;
              r_last  <= 1'b0;
            end else begin
              r_off   <= w_b_off;
              r_frame <= w_b_frame;
              r_data  <= w_b_data;
              r_keep  <= w_b_keep;
              r_last  <= w_b_last;
              if (r_last && r_ipg != '0) begin
                r_state <= GAP;
                r_valid <= 1'b0;
                r_gap   <= r_ipg;
              end
            end
          end
        end
        GAP: begin
          if (w_stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_stop  <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
          end else if (r_gap == 8'd1) begin
            r_state <= SEND;
            r_valid <= 1'b1;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_tvalid  = r_valid;
  assign m_tdata   = r_data;
  assign m_tkeep   = r_keep;
  assign m_tlast   = r_last;
  assign m_tuser   = '0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pkts_sent = r_pkts;

endmodule

// File: tb/tb_eth_axis_tx_pkt_gen.sv
// Directed bench for eth_axis_tx_pkt_gen: framing, pattern, back-pressure,
// gap, clamp, stop and asynchronous reset.
module tb_eth_axis_tx_pkt_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [13:0] cfg_pkt_len = '0;
  logic [31:0] cfg_pkt_cnt = '0;
  logic [7:0]  cfg_ipg = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  eth_axis_tx_pkt_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_pkt_len (cfg_pkt_len),
    .cfg_pkt_cnt (cfg_pkt_cnt),
    .cfg_ipg     (cfg_ipg),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .busy        (busy),
    .done        (done),
    .pkts_sent   (pkts_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) n_done++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_beat(input int p, input int off, input int len,
                          output logic [63:0] d, output logic [7:0] k,
                          output logic l);
    d = '0;
    k = '0;
    for (int b = 0; b < 8; b++) begin
      if (off + b < len) begin
        k[b] = 1'b1;
        d[8*b +: 8] = 8'((p + off + b) % 256);
      end
    end
    l = (off + 8 >= len);
  endtask

  task automatic run_frame(input int p, input int len, input int duty,
                           input int stop_beat, output int idle,
                           output int acc, output logic [63:0] d0,
                           output logic [63:0] dl, output logic [7:0] kl);
    int off = 0;
    int guard = 0;
    bit got = 0;
    bit a;
    logic [63:0] ed;
    logic [7:0] ek;
    logic el;
    idle = 0;
    acc = 0;
    d0 = '0;
    dl = '0;
    kl = '0;
    while (off < len && guard < 2000) begin
      guard++;
      if (m_tvalid) begin
        exp_beat(p, off, len, ed, ek, el);
        chk($sformatf("f%0d_tdata@%0d", p, off), m_tdata, ed);
        chk($sformatf("f%0d_tkeep@%0d", p, off), m_tkeep, ek);
        chk($sformatf("f%0d_tlast@%0d", p, off), m_tlast, el);
        if (off == 0) d0 = m_tdata;
        if (el) begin
          dl = m_tdata;
          kl = m_tkeep;
        end
        got = 1;
      end else if (!got) begin
        idle++;
      end else begin
        chk($sformatf("f%0d_tvalid_hold@%0d", p, off), m_tvalid, 1);
      end
      cfg_stop = m_tvalid && (stop_beat >= 0) && (off == stop_beat * 8);
      m_tready = ($urandom_range(99) < duty);
      a = m_tvalid && m_tready;
      tick();
      if (a) begin
        off += 8;
        acc++;
      end
    end
    cfg_stop = 1'b0;
    chk($sformatf("f%0d_complete", p), 64'(off >= len), 1);
  endtask

  initial begin
    int idle, acc, total;
    logic [63:0] d0, dl;
    logic [7:0] kl;

    // reset state
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkts", pkts_sent, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tuser", m_tuser, 0);
    rst_n = 1'b1;
    tick();

    // single 64-byte frame
    cfg_pkt_len = 64;
    cfg_pkt_cnt = 1;
    cfg_ipg = 0;
    n_done = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("t1_first_valid", m_tvalid, 1);
    chk("t1_busy", busy, 1);
    run_frame(0, 64, 100, -1, idle, acc, d0, dl, kl);
    chk("t1_beats", acc, 8);
    chk("t1_beat0", d0, 64'h0706050403020100);
    chk("t1_lastkeep", kl, 8'hFF);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_pkts", pkts_sent, 1);
    tick();
    tick();
    chk("t1_done_once", n_done, 1);
    chk("t1_idle_valid", m_tvalid, 0);

    // odd length, back-to-back
    cfg_pkt_len = 67;
    cfg_pkt_cnt = 2;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(0, 67, 100, -1, idle, acc, d0, dl, kl);
    chk("t2_beats", acc, 9);
    chk("t2_lastkeep", kl, 8'h07);
    chk("t2_lastdata", dl, 64'h0000000000424140);
    chk("t2_pkts_mid", pkts_sent, 1);
    run_frame(1, 67, 100, -1, idle, acc, d0, dl, kl);
    chk("t2_b2b_idle", idle, 0);
    chk("t2_f1_beat0", d0, 64'h0807060504030201);
    chk("t2_done", done, 1);
    chk("t2_pkts", pkts_sent, 2);
    tick();

    // back-pressure; start and stop together (start wins)
    cfg_pkt_len = 100;
    cfg_pkt_cnt = 3;
    cfg_start = 1'b1;
    cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    total = 0;
    for (int p = 0; p < 3; p++) begin
      run_frame(p, 100, 30, -1, idle, acc, d0, dl, kl);
      total += acc;
    end
    chk("t3_total_beats", total, 39);
    chk("t3_lastkeep", kl, 8'h0F);
    chk("t3_lastdata", dl, 64'h0000000065646362);
    chk("t3_pkts", pkts_sent, 3);
    chk("t3_done", done, 1);
    m_tready = 1'b1;
    tick();

    // gap and length clamp
    cfg_pkt_len = 10;
    cfg_pkt_cnt = 2;
    cfg_ipg = 5;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(0, 64, 100, -1, idle, acc, d0, dl, kl);
    chk("t4_clamp_beats", acc, 8);
    chk("t4_gap_valid", m_tvalid, 0);
    run_frame(1, 64, 100, -1, idle, acc, d0, dl, kl);
    chk("t4_gap_cycles", idle, 5);
    chk("t4_lastdata", dl, 64'h403F3E3D3C3B3A39);
    chk("t4_pkts", pkts_sent, 2);
    chk("t4_done", done, 1);
    tick();

    // continuous run stopped during frame 4
    cfg_pkt_len = 64;
    cfg_pkt_cnt = 0;
    cfg_ipg = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    n_done = 0;
    for (int p = 0; p < 4; p++)
      run_frame(p, 64, 100, -1, idle, acc, d0, dl, kl);
    chk("t5_pkts_mid", pkts_sent, 4);
    run_frame(4, 64, 100, 3, idle, acc, d0, dl, kl);
    chk("t5_f4_beats", acc, 8);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 1);
    chk("t5_pkts", pkts_sent, 5);
    tick();
    chk("t5_done_once", n_done, 1);
    cfg_pkt_cnt = 1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("t5_restart_pkts", pkts_sent, 0);
    chk("t5_restart_beat0", m_tdata, 64'h0706050403020100);
    run_frame(0, 64, 100, -1, idle, acc, d0, dl, kl);
    chk("t5_restart_done", done, 1);
    tick();

    // asynchronous reset mid-frame
    cfg_pkt_cnt = 2;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(0, 64, 100, -1, idle, acc, d0, dl, kl);
    m_tready = 1'b1;
    tick();
    tick();
    chk("t6_pre_pkts", pkts_sent, 1);
    chk("t6_pre_valid", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", m_tvalid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_tdata", m_tdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_busy", busy, 0);
    chk("t6_post_pkts", pkts_sent, 0);
    tick();
    chk("t6_post_valid", m_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
